puf_key_gen: RTL

PUF response conditioner and key assembler that sits directly upstream of the AES core and drives its 128-bit key input. It walks a challenge index over all key-bit positions and collects an odd number of raw PUF responses per challenge. A majority vote over those responses decides each key bit. It presents the finished key with a level-valid flag and counts the bits whose votes were not unanimous, as a reliability indicator.

---
 rtl/puf_key_gen_if.sv | 26 ++
 rtl/puf_key_gen.sv | 109 ++++++++++
 2 files changed

// File: rtl/puf_key_gen_if.sv
// Bundle of the key-generation request, PUF challenge/response and key-delivery signals.
// The bench drives the master side; puf_key_gen sits on the slave side.
interface puf_key_gen_if #(
    parameter int KEY_W = 128,
    parameter int CH_W  = 7
);
    logic             start;
    logic             puf_resp;
    logic             puf_resp_valid;
    logic [CH_W-1:0]  challenge;
    logic             challenge_req;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic [7:0]       unstable_cnt;

    modport master (
        output start, puf_resp, puf_resp_valid,
        input  challenge, challenge_req, key_out, key_valid, busy, unstable_cnt
    );

    modport slave (
        input  start, puf_resp, puf_resp_valid,
        output challenge, challenge_req, key_out, key_valid, busy, unstable_cnt
    );
endinterface

// File: rtl/puf_key_gen.sv
// PUF response conditioner: majority-votes VOTES raw samples per challenge into one key bit
// and assembles a KEY_W-bit key, counting non-unanimous bits as a reliability indicator.
module puf_key_gen #(
    parameter int KEY_W = 128,
    parameter int VOTES = 5,
    parameter int CH_W  = 7
) (
    input  logic         clk,
    input  logic         reset,
    puf_key_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SAMPLE, VOTE, DONE} state_t;

    localparam logic [3:0]      VOTES_M1  = 4'(VOTES - 1);
    localparam logic [3:0]      VOTES_ALL = 4'(VOTES);
    localparam logic [3:0]      MAJORITY  = 4'((VOTES + 1) / 2);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(KEY_W - 1);
    localparam logic [CH_W-1:0] CH_ONE    = CH_W'(1);

    state_t           state_r;
    logic [3:0]       sample_cnt_r;
    logic [3:0]       ones_cnt_r;
    logic [CH_W-1:0]  challenge_r;
    logic             challenge_req_r;
    logic [KEY_W-1:0] key_r;
    logic             key_valid_r;
    logic             busy_r;
    logic [7:0]       unstable_r;

    function automatic logic majority_bit(input logic [3:0] ones);
        return (ones >= MAJORITY);
    endfunction

    function automatic logic vote_split(input logic [3:0] ones);
        return (ones != 4'd0) && (ones != VOTES_ALL);
    endfunction

    // Key-generation FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            sample_cnt_r    <= 4'd0;
            ones_cnt_r      <= 4'd0;
            challenge_r     <= '0;
            challenge_req_r <= 1'b0;
            key_r           <= '0;
            key_valid_r     <= 1'b0;
            busy_r          <= 1'b0;
            unstable_r      <= 8'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_r         <= SAMPLE;
                        sample_cnt_r    <= 4'd0;
                        ones_cnt_r      <= 4'd0;
                        challenge_r     <= '0;
                        challenge_req_r <= 1'b1;
                        key_r           <= '0;
                        key_valid_r     <= 1'b0;
                        busy_r          <= 1'b1;
                        unstable_r      <= 8'd0;
                    end
                end
                SAMPLE: begin
                    if (bus.puf_resp_valid) begin
                        ones_cnt_r   <= ones_cnt_r + {3'b000, bus.puf_resp};
                        sample_cnt_r <= sample_cnt_r + 4'd1;
                        if (sample_cnt_r == VOTES_M1) begin
                            state_r         <= VOTE;
                            challenge_req_r <= 1'b0;
                        end
                    end
                end
                VOTE: begin
                    key_r[challenge_r] <= majority_bit(ones_cnt_r);
                    // Saturate rather than wrap so a very noisy PUF never looks healthy.
                    if (vote_split(ones_cnt_r) && (unstable_r != 8'hFF)) begin
                        unstable_r <= unstable_r + 8'd1;
                    end
                    sample_cnt_r <= 4'd0;
                    ones_cnt_r   <= 4'd0;
                    if (challenge_r == LAST_CH) begin
                        state_r     <= DONE;
                        busy_r      <= 1'b0;
                        key_valid_r <= 1'b1;
                    end else begin
                        state_r         <= SAMPLE;
                        challenge_r     <= challenge_r + CH_ONE;
                        challenge_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    challenge_req_r <= 1'b0;
                    busy_r          <= 1'b0;
                    key_valid_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.challenge     = challenge_r;
    assign bus.challenge_req = challenge_req_r;
    assign bus.key_out       = key_r;
    assign bus.key_valid     = key_valid_r;
    assign bus.busy          = busy_r;
    assign bus.unstable_cnt  = unstable_r;
endmodule
